mc_control_fsm: RTL

- Main control state machine for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit aluop into the existing ALU decoder, plus all mux selects and write enables.
- Handshakes with a variable-latency memory through mem_req/mem_ready and counts retired instructions.

---
 rtl/mc_control_fsm.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, handshakes with variable-latency memory, counts retired instructions.
// Optional feature: define ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module mc_control_fsm #(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [5:0]           op,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 iord,
   output logic                 memwrite,
   output logic                 irwrite,
   output logic                 regdst,
   output logic                 memtoreg,
   output logic                 regwrite,
   output logic                 alusrca,
   output logic [1:0]           alusrcb,
   output logic [1:0]           aluop,
   output logic [1:0]           pcsrc,
   output logic                 pcen,
   output logic [INSTRET_W-1:0] instret,
   output logic                 illegal
);

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
`ifdef ILLEGAL_TRAP_EN
      JEX     = 4'd11,
      TRAP    = 4'd12
`else
      JEX     = 4'd11
`endif
   } state_t;

   state_t state, next;

   // Raw (ungated) enables; the reset cycle forces them low below.
   logic mem_req_raw, memwrite_raw, irwrite_raw, regwrite_raw;
   logic pcwrite, branch, retire;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= FETCH;
      else          state <= next;
   end

   always_comb begin
      next         = state;
      mem_req_raw  = 1'b0;
      iord         = 1'b0;
      memwrite_raw = 1'b0;
      irwrite_raw  = 1'b0;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      regwrite_raw = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      aluop        = 2'b00;
      pcsrc        = 2'b00;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      retire       = 1'b0;
      case (state)
         FETCH: begin
            mem_req_raw = 1'b1;
            alusrcb     = 2'b01;
            if (mem_ready) begin
               irwrite_raw = 1'b1;
               pcwrite     = 1'b1;
               next        = DECODE;
            end
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: next = MEMADR;
               OP_RTYPE:     next = RTYPEEX;
               OP_BEQ:       next = BEQEX;
               OP_ADDI:      next = ADDIEX;
               OP_J:         next = JEX;
`ifdef ILLEGAL_TRAP_EN
               default:      next = TRAP;
`else
               default:      next = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            next    = (op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_req_raw = 1'b1;
            iord        = 1'b1;
            if (mem_ready) next = MEMWB;
         end
         MEMWB: begin
            memtoreg     = 1'b1;
            regwrite_raw = 1'b1;
            retire       = 1'b1;
            next         = FETCH;
         end
         MEMWR: begin
            // Strobe stays up across the whole wait so slow memories see a stable write.
            mem_req_raw  = 1'b1;
            iord         = 1'b1;
            memwrite_raw = 1'b1;
            if (mem_ready) begin
               retire = 1'b1;
               next   = FETCH;
            end
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            next    = RTYPEWB;
         end
         RTYPEWB: begin
            regdst       = 1'b1;
            regwrite_raw = 1'b1;
            retire       = 1'b1;
            next         = FETCH;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
            retire  = 1'b1;
            next    = FETCH;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            next    = ADDIWB;
         end
         ADDIWB: begin
            regwrite_raw = 1'b1;
            retire       = 1'b1;
            next         = FETCH;
         end
         JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
            retire  = 1'b1;
            next    = FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         TRAP: next = TRAP;
`endif
         default: next = FETCH;
      endcase
   end

   assign mem_req  = reset_n & mem_req_raw;
   assign memwrite = reset_n & memwrite_raw;
   assign irwrite  = reset_n & irwrite_raw;
   assign regwrite = reset_n & regwrite_raw;
   assign pcen     = reset_n & (pcwrite | (branch & zero));

   always_ff @(posedge clk) begin
      if (!reset_n)    instret <= '0;
      else if (retire) instret <= instret + 1'b1;
   end

`ifdef ILLEGAL_TRAP_EN
   always_ff @(posedge clk) begin
      if (!reset_n)          illegal <= 1'b0;
      else if (next == TRAP) illegal <= 1'b1;
   end
`else
   assign illegal = 1'b0;
`endif

endmodule
